ddr3_port_arbiter: RTL and testbench
====================================

Name: ddr3_port_arbiter

Overview:
- Shares one ddr3_cache_ctrl word port among PORTS requesters, e.g. instruction fetch, data access and VGA/DMA.
- Arbitration is round-robin. The winning request is latched into registers and held until the controller's single-cycle ack. The requester receives that ack and the read data.
- Forces a one-cycle request-low gap after every ack, because the controller re-launches if rd/we is still high when it returns to idle.
- Masks the controller's spontaneous post-init ack.

Parameters:
- PORTS, 3, number of requesters (2..8).
- WAIT_INIT, 1, if 1 no grant is issued until the first controller ack (init done) is seen.
- TIMEOUT, 4096, BUSY cycles without ack before timeout_o is set. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_addr_i  in  32*PORTS  per-port byte address; port k occupies bits [32k+31:32k].
- s_data_i  in  32*PORTS  per-port write data, same packing.
- s_we_i  in  PORTS  per-port write request.
- s_rd_i  in  PORTS  per-port read request.
- s_data_o  out  32  read data, broadcast to all ports, valid only with the port's s_ack_o.
- s_ack_o  out  PORTS  per-port completion pulse, one cycle.
- m_addr_o  out  32  to the controller's addr_i, registered.
- m_data_o  out  32  to the controller's data_i, registered.
- m_we_o  out  1  to the controller's we_i, registered.
- m_rd_o  out  1  to the controller's rd_i, registered.
- m_data_i  in  32  from the controller's data_o.
- m_ack_i  in  1  from the controller's ack_o.
- grant_o  out  PORTS  one-hot current owner, 0 when no owner.
- busy_o  out  1  high in BUSY.
- timeout_o  out  1  sticky, set when a transaction exceeds TIMEOUT cycles.

Behaviour:
- Reset (async, rst=1) values:
  - All outputs 0; m_addr_o, m_data_o, m_we_o, m_rd_o, grant_o, busy_o and timeout_o all 0.
  - last_grant = PORTS-1, so port 0 has first priority.
  - State = WAIT_INIT if WAIT_INIT=1, else IDLE.
- Request definition: port k requests when s_rd_i[k] or s_we_i[k] is high.
  - If both are high, the request is a read (m_rd_o=1, m_we_o=0), matching the controller's read priority. Exactly one ack is returned.
- States:
  - WAIT_INIT: m_rd_o and m_we_o held low. On m_ack_i go to IDLE; that ack is not forwarded to any port.
  - IDLE: if any port requests, select the first requesting port searching from last_grant+1 with wrap-around. Latch its addr, data, rd and we into the m_* registers, set grant_o, and go to BUSY. Winner's outputs appear the cycle after the request is seen.
  - BUSY: m_* outputs stay stable regardless of requester activity.
    - On m_ack_i, s_ack_o[g] = 1 for that same cycle (combinational from m_ack_i and the BUSY state).
    - s_data_o = m_data_i in that cycle.
    - Next edge: clear m_rd_o, m_we_o and grant_o; set last_grant = g; go to RELEASE.
  - RELEASE: exactly one cycle with m_rd_o and m_we_o low. The controller is returning END to IDLE during this cycle. Then go to IDLE.
- Back-to-back throughput: minimum 3 arbiter cycles of overhead per transaction (grant, ack, release) plus controller latency.
- Ack masking: m_ack_i in WAIT_INIT, IDLE or RELEASE never produces any s_ack_o.
- Withdrawn request: if a requester drops rd/we while BUSY, the transaction still completes and the ack is still pulsed to that port.
- Same-port re-request: a port still requesting in RELEASE, or re-requesting in IDLE, competes normally. Round-robin means it loses to any other requester.
- s_data_o outside an ack cycle: equals m_data_i, unqualified.
- Timeout counter: 16-bit, cleared on entry to BUSY, incremented each BUSY cycle, saturating.
  - When the counter equals TIMEOUT and TIMEOUT≠0, timeout_o is set and stays set until reset.
  - The transaction is not abandoned.
- Reset mid-transaction: all state is cleared immediately and m_rd_o/m_we_o drop asynchronously. Because the controller also resets, no ack is owed.

Test Plan:
- Init mask: WAIT_INIT=1, port0 rd from cycle 0; m_ack_i pulse at cycle 5 -> no s_ack_o, m_rd_o stays 0 until cycle 6. Then m_rd_o=1 with m_addr_o = port0 addr.
- Single read: port1 rd addr 0x0000_1004; m_ack_i after 4 BUSY cycles with m_data_i=0xCAFEBABE -> s_ack_o=3'b010 for 1 cycle, s_data_o=0xCAFEBABE. Next cycle m_rd_o=0 (RELEASE).
- Round-robin: all 3 ports request continuously, fixed 2-cycle ack latency -> grant order 0,1,2,0,1,2, each ack going to the matching port. Never two consecutive grants to the same port.
- Write with withdrawal: port2 we addr 0x40 data 0x12345678, dropped after 1 BUSY cycle -> m_we_o, m_addr_o and m_data_o held until ack; s_ack_o[2] still pulses.
- Rd+we both high on port0 -> m_rd_o=1, m_we_o=0, exactly one ack.
- Timeout/reset: TIMEOUT=8, no ack -> timeout_o rises at BUSY cycle 8 and stays high. Async rst mid-BUSY -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one ddr3_cache_ctrl word port among PORTS requesters.
// Holds the winning request in registers until ack, then forces a one-cycle rd/we-low gap.
module ddr3_port_arbiter #(
    parameter int PORTS     = 3,
    parameter int WAIT_INIT = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*PORTS-1:0] s_addr_i,
    input  logic [32*PORTS-1:0] s_data_i,
    input  logic [PORTS-1:0]    s_we_i,
    input  logic [PORTS-1:0]    s_rd_i,
    output logic [31:0]         s_data_o,
    output logic [PORTS-1:0]    s_ack_o,
    output logic [31:0]         m_addr_o,
    output logic [31:0]         m_data_o,
    output logic                m_we_o,
    output logic                m_rd_o,
    input  logic [31:0]         m_data_i,
    input  logic                m_ack_i,
    output logic [PORTS-1:0]    grant_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [15:0] TIMEOUT_LIM = (TIMEOUT > 65535) ? 16'hFFFF : 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    localparam state_t RESET_STATE = (WAIT_INIT != 0) ? ST_WAIT_INIT : ST_IDLE;

    state_t           state, state_nxt;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    cur_idx;
    logic [GW-1:0]    win_idx;
    logic             win_found;
    logic [PORTS-1:0] req;
    logic [31:0]      win_addr;
    logic [31:0]      win_data;
    logic             win_rd;
    logic             win_we;
    logic [15:0]      busy_cnt;
    logic [15:0]      busy_cnt_inc;
    logic             do_grant;
    logic             do_finish;

    assign req          = s_rd_i | s_we_i;
    assign busy_o       = (state == ST_BUSY);
    assign s_data_o     = m_data_i;
    assign busy_cnt_inc = (busy_cnt == 16'hFFFF) ? busy_cnt : busy_cnt + 16'd1;

    // Search ports above last_grant first, then wrap to the ports at or below it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (!win_found && req[j] && (j > int'(last_grant))) begin
                win_found = 1'b1;
                win_idx   = GW'(j);
            end
        end
        for (int j = 0; j < PORTS; j++) begin
            if (!win_found && req[j] && (j <= int'(last_grant))) begin
                win_found = 1'b1;
                win_idx   = GW'(j);
            end
        end
    end

    // Read wins over write when a port raises both, as the controller does.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_rd   = 1'b0;
        win_we   = 1'b0;
        for (int j = 0; j < PORTS; j++) begin
            if (win_idx == GW'(j)) begin
                win_addr = s_addr_i[32*j +: 32];
                win_data = s_data_i[32*j +: 32];
                win_rd   = s_rd_i[j];
                win_we   = s_we_i[j] & ~s_rd_i[j];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_finish = 1'b0;
        s_ack_o   = '0;
        unique case (state)
            ST_WAIT_INIT: begin
                if (m_ack_i) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (win_found) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ack_i) begin
                    do_finish = 1'b1;
                    s_ack_o   = grant_o;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_nxt;
    end

    // The async reset drops m_rd_o/m_we_o at once; the controller resets alongside, so no ack is owed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            m_addr_o   <= '0;
            m_data_o   <= '0;
            m_rd_o     <= 1'b0;
            m_we_o     <= 1'b0;
            grant_o    <= '0;
            cur_idx    <= '0;
            last_grant <= GW'(PORTS - 1);
            busy_cnt   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            if (do_grant) begin
                m_addr_o <= win_addr;
                m_data_o <= win_data;
                m_rd_o   <= win_rd;
                m_we_o   <= win_we;
                grant_o  <= PORTS'(1) << win_idx;
                cur_idx  <= win_idx;
                busy_cnt <= '0;
            end else if (do_finish) begin
                m_rd_o     <= 1'b0;
                m_we_o     <= 1'b0;
                grant_o    <= '0;
                last_grant <= cur_idx;
            end
            if (state == ST_BUSY) begin
                busy_cnt <= busy_cnt_inc;
                if ((TIMEOUT != 0) && (busy_cnt_inc == TIMEOUT_LIM)) timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: directed table, corner sequences and a
// random run checked every cycle against a behavioural model of the arbitration rules.
module tb_ddr3_port_arbiter;

    localparam int P  = 3;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [32*P-1:0]  s_addr_i;
    logic [32*P-1:0]  s_data_i;
    logic [P-1:0]     s_we_i;
    logic [P-1:0]     s_rd_i;
    logic [31:0]      s_data_o;
    logic [P-1:0]     s_ack_o;
    logic [31:0]      m_addr_o;
    logic [31:0]      m_data_o;
    logic             m_we_o;
    logic             m_rd_o;
    logic [31:0]      m_data_i;
    logic             m_ack_i;
    logic [P-1:0]     grant_o;
    logic             busy_o;
    logic             timeout_o;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.PORTS(P), .WAIT_INIT(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_we_i(s_we_i), .s_rd_i(s_rd_i),
        .s_data_o(s_data_o), .s_ack_o(s_ack_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_we_o(m_we_o), .m_rd_o(m_rd_o),
        .m_data_i(m_data_i), .m_ack_i(m_ack_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [31:0] addr, input logic [31:0] data);
        s_addr_i[32*k +: 32] = addr;
        s_data_i[32*k +: 32] = data;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy_o !== 1'b1 && n < 12) begin
            cyc();
            #1;
            n++;
        end
        check(name, busy_o, 1'b1);
    endtask

    // Reference model: one owner at a time, one quiet cycle after each ack,
    // round-robin search by modular arithmetic from the last owner.
    int          md_owner = -1;
    int          md_last  = P - 1;
    bit          md_gap   = 1'b0;
    bit          md_init  = 1'b0;
    bit          md_rd    = 1'b0;
    bit          md_we    = 1'b0;
    logic [31:0] md_addr  = '0;
    logic [31:0] md_data  = '0;
    int          md_cnt   = 0;
    bit          md_to    = 1'b0;
    int          md_p;

    always @(negedge clk) begin
        if (rst) begin
            md_owner = -1; md_last = P - 1; md_gap = 1'b0; md_init = 1'b0;
            md_rd = 1'b0; md_we = 1'b0; md_addr = '0; md_data = '0;
            md_cnt = 0; md_to = 1'b0;
        end else begin
            check("mon_busy",   busy_o,   md_owner >= 0);
            check("mon_grant",  grant_o,  (md_owner >= 0) ? (P'(1) << md_owner) : '0);
            check("mon_m_rd",   m_rd_o,   (md_owner >= 0) && md_rd);
            check("mon_m_we",   m_we_o,   (md_owner >= 0) && md_we);
            check("mon_m_addr", m_addr_o, md_addr);
            check("mon_m_data", m_data_o, md_data);
            check("mon_s_ack",  s_ack_o,  (md_owner >= 0 && m_ack_i) ? (P'(1) << md_owner) : '0);
            check("mon_s_data", s_data_o, m_data_i);
            check("mon_timeout", timeout_o, md_to);
            if (md_owner >= 0) begin
                md_cnt++;
                if (md_cnt == TO) md_to = 1'b1;
                if (m_ack_i) begin
                    md_last  = md_owner;
                    md_owner = -1;
                    md_gap   = 1'b1;
                end
            end else if (md_gap) begin
                md_gap = 1'b0;
            end else if (!md_init) begin
                if (m_ack_i) md_init = 1'b1;
            end else begin
                for (int i = 1; i <= P; i++) begin
                    md_p = (md_last + i) % P;
                    if (md_owner < 0 && (s_rd_i[md_p] || s_we_i[md_p])) begin
                        md_owner = md_p;
                        md_rd    = s_rd_i[md_p];
                        md_we    = s_we_i[md_p] && !s_rd_i[md_p];
                        md_addr  = s_addr_i[32*md_p +: 32];
                        md_data  = s_data_i[32*md_p +: 32];
                        md_cnt   = 0;
                    end
                end
            end
        end
    end

    // Controller stand-in: acks 0..4 cycles after rd/we rises, optional stray acks otherwise.
    bit ctl_started = 1'b0;
    int ctl_lat     = 0;

    task automatic ctrl_step(input bit spurious);
        if (!ctl_started && (m_rd_o || m_we_o)) begin
            ctl_started = 1'b1;
            ctl_lat     = $urandom_range(0, 4);
        end
        if (ctl_started) begin
            if (ctl_lat == 0) begin
                m_ack_i     = 1'b1;
                ctl_started = 1'b0;
            end else begin
                m_ack_i = 1'b0;
                ctl_lat--;
            end
        end else begin
            m_ack_i = spurious && ($urandom_range(0, 7) == 0);
        end
    endtask

    typedef struct {
        logic [P-1:0] rd;
        logic [P-1:0] we;
        logic [P-1:0] exp_grant;
        logic         exp_rd;
        logic         exp_we;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_data;
        int           lat;
        logic [31:0]  rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        s_addr_i = '0; s_data_i = '0; s_rd_i = '0; s_we_i = '0;
        m_data_i = '0; m_ack_i = 1'b0;

        // Round-robin history starts at last=0 after the init sequence.
        vecs[0] = '{3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 32'h0000_1004, 32'hD000_0001, 4, 32'hCAFE_BABE};
        vecs[1] = '{3'b000, 3'b100, 3'b100, 1'b0, 1'b1, 32'h0000_1008, 32'hD000_0002, 1, 32'h1111_0001};
        vecs[2] = '{3'b001, 3'b001, 3'b001, 1'b1, 1'b0, 32'h0000_1000, 32'hD000_0000, 0, 32'h2222_0002};
        vecs[3] = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 32'h0000_1004, 32'hD000_0001, 2, 32'h3333_0003};
        vecs[4] = '{3'b101, 3'b000, 3'b100, 1'b1, 1'b0, 32'h0000_1008, 32'hD000_0002, 3, 32'h4444_0004};
        vecs[5] = '{3'b011, 3'b000, 3'b001, 1'b1, 1'b0, 32'h0000_1000, 32'hD000_0000, 1, 32'h5555_0005};
        vecs[6] = '{3'b000, 3'b001, 3'b001, 1'b0, 1'b1, 32'h0000_1000, 32'hD000_0000, 2, 32'h6666_0006};
        vecs[7] = '{3'b001, 3'b100, 3'b100, 1'b0, 1'b1, 32'h0000_1008, 32'hD000_0002, 0, 32'h7777_0007};

        repeat (2) @(posedge clk);
        #2;
        check("rst_m_rd", m_rd_o, 1'b0);
        check("rst_m_we", m_we_o, 1'b0);
        check("rst_m_addr", m_addr_o, 32'h0);
        check("rst_grant", grant_o, 3'b000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);

        // Init mask: stray ack at cycle 5 is swallowed, first grant follows.
        cyc();
        rst = 1'b0;
        for (int k = 0; k < P; k++) set_port(k, 32'h1000 + 32'(4 * k), 32'hD000_0000 + 32'(k));
        s_rd_i = 3'b001;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) cyc();
            m_ack_i = (c == 5);
            #1;
            check($sformatf("init_s_ack_c%0d", c), s_ack_o, 3'b000);
            check($sformatf("init_m_rd_c%0d", c), m_rd_o, 1'b0);
        end
        cyc();
        #1;
        check("init_m_rd", m_rd_o, 1'b1);
        check("init_m_addr", m_addr_o, 32'h0000_1000);
        check("init_grant", grant_o, 3'b001);
        m_ack_i = 1'b1; m_data_i = 32'h5555_AAAA; s_rd_i = '0;
        #1;
        check("init_s_ack", s_ack_o, 3'b001);
        check("init_s_data", s_data_o, 32'h5555_AAAA);
        cyc();
        m_ack_i = 1'b0;
        #1;
        check("init_release_rd", m_rd_o, 1'b0);

        for (int i = 0; i < 8; i++) begin
            cyc();
            s_rd_i = vecs[i].rd;
            s_we_i = vecs[i].we;
            #1;
            wait_busy($sformatf("v%0d_wait", i));
            check($sformatf("v%0d_grant", i), grant_o, vecs[i].exp_grant);
            check($sformatf("v%0d_m_rd", i), m_rd_o, vecs[i].exp_rd);
            check($sformatf("v%0d_m_we", i), m_we_o, vecs[i].exp_we);
            check($sformatf("v%0d_m_addr", i), m_addr_o, vecs[i].exp_addr);
            check($sformatf("v%0d_m_data", i), m_data_o, vecs[i].exp_data);
            s_rd_i = '0;
            s_we_i = '0;
            repeat (vecs[i].lat) begin
                cyc();
                #1;
            end
            m_ack_i  = 1'b1;
            m_data_i = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_s_ack", i), s_ack_o, vecs[i].exp_grant);
            check($sformatf("v%0d_s_data", i), s_data_o, vecs[i].rdata);
            cyc();
            m_ack_i = 1'b0;
            #1;
            check($sformatf("v%0d_rel_rd", i), m_rd_o, 1'b0);
            check($sformatf("v%0d_rel_we", i), m_we_o, 1'b0);
            check($sformatf("v%0d_rel_grant", i), grant_o, 3'b000);
        end

        // Continuous requests on all ports, 2-cycle ack latency: strict rotation 0,1,2,...
        cyc();
        s_rd_i = 3'b111;
        #1;
        for (int t = 0; t < 6; t++) begin
            wait_busy($sformatf("rr%0d_wait", t));
            check($sformatf("rr%0d_grant", t), grant_o, 3'(1) << (t % 3));
            repeat (2) begin
                cyc();
                #1;
            end
            m_ack_i  = 1'b1;
            m_data_i = 32'h0000_0100 + 32'(t);
            #1;
            check($sformatf("rr%0d_s_ack", t), s_ack_o, 3'(1) << (t % 3));
            cyc();
            m_ack_i = 1'b0;
            #1;
            check($sformatf("rr%0d_rel", t), busy_o, 1'b0);
        end
        s_rd_i = '0;

        // Write whose requester withdraws and scribbles its inputs while BUSY.
        cyc();
        set_port(2, 32'h0000_0040, 32'h1234_5678);
        s_we_i = 3'b100;
        #1;
        wait_busy("wr_wait");
        check("wr_grant", grant_o, 3'b100);
        check("wr_m_rd", m_rd_o, 1'b0);
        cyc();
        s_we_i = '0;
        set_port(2, 32'hDEAD_0000, 32'hBAD0_BAD0);
        #1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            check("wr_hold_we", m_we_o, 1'b1);
            check("wr_hold_addr", m_addr_o, 32'h0000_0040);
            check("wr_hold_data", m_data_o, 32'h1234_5678);
        end
        m_ack_i = 1'b1;
        #1;
        check("wr_s_ack", s_ack_o, 3'b100);
        cyc();
        m_ack_i = 1'b0;
        #1;
        check("wr_rel_we", m_we_o, 1'b0);

        // Random traffic; the monitor compares every cycle against the model.
        for (int c = 0; c < 400; c++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) begin
                s_rd_i = '0;
                s_we_i = '0;
            end else begin
                s_rd_i = P'($urandom);
                s_we_i = P'($urandom);
            end
            for (int k = 0; k < P; k++) set_port(k, $urandom, $urandom);
            m_data_i = $urandom;
            ctrl_step(1'b1);
            #1;
        end
        s_rd_i = '0;
        s_we_i = '0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            ctrl_step(1'b0);
            #1;
        end
        check("drain_idle", busy_o, 1'b0);

        // Timeout: no ack, flag rises after 8 BUSY cycles and sticks; then async reset mid-BUSY.
        cyc();
        m_ack_i = 1'b0;
        s_rd_i  = 3'b010;
        #1;
        wait_busy("to_wait");
        s_rd_i = '0;
        check("to_start", timeout_o, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            #1;
            check($sformatf("to_busy%0d", k), timeout_o, k >= TO);
        end
        check("to_still_busy", busy_o, 1'b1);
        #1;
        rst      = 1'b1;
        m_ack_i  = 1'b1;
        m_data_i = '0;
        #1;
        check("arst_m_rd", m_rd_o, 1'b0);
        check("arst_m_we", m_we_o, 1'b0);
        check("arst_m_addr", m_addr_o, 32'h0);
        check("arst_m_data", m_data_o, 32'h0);
        check("arst_grant", grant_o, 3'b000);
        check("arst_busy", busy_o, 1'b0);
        check("arst_timeout", timeout_o, 1'b0);
        check("arst_s_ack", s_ack_o, 3'b000);
        cyc();
        cyc();
        rst     = 1'b0;
        m_ack_i = 1'b0;
        #1;
        check("post_rst_busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
